// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if -- decode/writeback bus for the reg_file_sb register file.
//   slave  : seen by the register file (reads, writeback, alloc, flush in;
//            read data, busy flags, alloc_err, ready out)
//   master : seen by the pipeline driving it
// Parameters: XLEN (data width), NUM_REGS (register count, power of two >= 4).
interface reg_file_sb_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            we;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] wd;
  logic            alloc_valid;
  logic [AW-1:0]   alloc_addr;
  logic            flush;
  logic            alloc_err;
  logic            ready;

  modport slave (
    input  rs1_addr, rs2_addr, we, rd_addr, wd, alloc_valid, alloc_addr, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, alloc_err, ready
  );

  modport master (
    output rs1_addr, rs2_addr, we, rd_addr, wd, alloc_valid, alloc_addr, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, alloc_err, ready
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb -- parametrised integer register file with post-reset zeroing
// sweep, per-register busy scoreboard and pipeline flush.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : reg_file_sb_if.slave (2 combinational read ports with busy flags,
//            1 write port, alloc/flush scoreboard control, alloc_err, ready)
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle writeback
// data to the read ports (the written register also reads not-busy).
module reg_file_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_file_sb_if.slave   bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                alloc_err_q, alloc_err_d;
  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];

  logic [XLEN-1:0]     rs1_data_o, rs2_data_o;
  logic                rs1_busy_o, rs2_busy_o, ready_o;

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      idx_q       <= AW'(1);
      busy_q      <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      alloc_err_q <= alloc_err_d;
    end
  end

  // Register storage has no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Next-state, storage and scoreboard update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    alloc_err_d = 1'b0;
    regs_d      = regs_q;

    unique case (state_q)
      INIT: begin
        regs_d[idx_q] = '0;
        idx_d         = idx_q + AW'(1);
        if (idx_q == AW'(NUM_REGS - 1)) state_d = RUN;
      end
      RUN: begin
        if (bus.we && (bus.rd_addr != '0)) regs_d[bus.rd_addr] = bus.wd;

        if (bus.flush) begin
          busy_d = '0;
        end else begin
          // Clear before set so a same-cycle alloc of the written register wins.
          if (bus.we) busy_d[bus.rd_addr] = 1'b0;
          if (bus.alloc_valid && (bus.alloc_addr != '0)) busy_d[bus.alloc_addr] = 1'b1;
          alloc_err_d = bus.alloc_valid && (bus.alloc_addr != '0) &&
                        busy_q[bus.alloc_addr] &&
                        !(bus.we && (bus.rd_addr == bus.alloc_addr));
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Outputs
  always_comb begin
    ready_o    = (state_q == RUN);
    rs1_data_o = '0;
    rs2_data_o = '0;
    rs1_busy_o = 1'b0;
    rs2_busy_o = 1'b0;

    if (state_q == RUN) begin
      if (bus.rs1_addr != '0) begin
        rs1_data_o = regs_q[bus.rs1_addr];
        rs1_busy_o = busy_q[bus.rs1_addr];
      end
      if (bus.rs2_addr != '0) begin
        rs2_data_o = regs_q[bus.rs2_addr];
        rs2_busy_o = busy_q[bus.rs2_addr];
      end
`ifdef REG_FILE_BYPASS_EN
      if (bus.we && (bus.rd_addr != '0) && (bus.rd_addr == bus.rs1_addr)) begin
        rs1_data_o = bus.wd;
        rs1_busy_o = 1'b0;
      end
      if (bus.we && (bus.rd_addr != '0) && (bus.rd_addr == bus.rs2_addr)) begin
        rs2_data_o = bus.wd;
        rs2_busy_o = 1'b0;
      end
`endif
    end
  end

  assign bus.rs1_data  = rs1_data_o;
  assign bus.rs2_data  = rs2_data_o;
  assign bus.rs1_busy  = rs1_busy_o;
  assign bus.rs2_busy  = rs2_busy_o;
  assign bus.ready     = ready_o;
  assign bus.alloc_err = alloc_err_q;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised integer register file for the RISC-V core. Successor to the fixed 32x32, 2-read/1-write register file.
- Adds a post-reset zeroing sequencer, a per-register busy scoreboard for hazard detection, and a pipeline flush.
- Adds an optional write-to-read bypass.
- Sits between decode (read/allocate) and writeback (write/release).

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers; power of two, at least 4; index 0 is hardwired zero
AW, $clog2(NUM_REGS), register address width (derived, do not override)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
rs1_busy  out  1  rs1 has a pending write (combinational)
rs2_busy  out  1  rs2 has a pending write (combinational)
we  in  1  writeback enable
rd_addr  in  AW  writeback destination
wd  in  XLEN  writeback data
alloc_valid  in  1  decode claims a destination register
alloc_addr  in  AW  register being claimed
flush  in  1  clear all busy bits
alloc_err  out  1  registered; pulses for one cycle when an alloc hits an already-busy register
ready  out  1  high once zeroing has finished

Behaviour:
Reset:
- While rst_n=0: ready=0, alloc_err=0, all busy bits=0, state=INIT, init index=1.
- Register contents are not reset directly; the INIT sweep zeroes them.

INIT state:
- Each cycle, writes 0 to reg[idx] and increments idx.
- After idx=NUM_REGS-1 is written, go to RUN. ready rises on the next edge, i.e. NUM_REGS-1 cycles after rst_n deasserts.
- In INIT: we, alloc_valid and flush are ignored; rs*_data=0; rs*_busy=0.

RUN state:
- Read: rsN_data = 0 if rsN_addr=0, else reg[rsN_addr].
- Write: if we and rd_addr!=0, reg[rd_addr] <= wd at the edge. Writes to x0 are discarded.
- Busy set: alloc_valid and alloc_addr!=0 sets busy[alloc_addr].
- Busy clear: we clears busy[rd_addr].
- Simultaneous alloc and write to the same register: set wins; busy stays 1 and data is written.
- A write to a non-busy register is legal; data is written and busy is unchanged.
- alloc_err <= alloc_valid & (alloc_addr!=0) & busy[alloc_addr] & ~(we & rd_addr==alloc_addr). busy stays 1 in this case.
- flush clears every busy bit and overrides alloc in the same cycle (no set, alloc_err=0). A write in the flush cycle still updates data.
- rsN_busy = busy[rsN_addr]; x0 always reads not-busy.
- Reset asserted mid-RUN: async return to INIT; outputs take their reset values immediately.
- No state other than INIT and RUN. State encoding is free; no illegal state is reachable.

Optional Feature:
REG_FILE_BYPASS_EN
- Defined: in RUN, if we and rd_addr!=0 and rd_addr==rsN_addr, then rsN_data=wd and rsN_busy=0 in the same cycle (write-through forwarding). A same-cycle alloc to that register does not affect the read.
- Undefined: reads return the pre-edge register value. The new data is visible the cycle after the write.

Test Plan:
1. Deassert rst_n, hold all inputs 0. Expect ready=0 for 31 cycles, then ready=1; reading all 32 addresses returns 0 (NUM_REGS=32).
2. After ready: write x5=0xDEADBEEF, then read rs1=5, rs2=0. Expect rs1_data=0xDEADBEEF next cycle and rs2_data=0. Then write x0=0x1234; x0 still reads 0.
3. alloc x7, then set rs1=7: rs1_busy=1. Alloc x7 again: alloc_err=1 for one cycle. Write x7=0x55: busy clears and rs1_data=0x55.
4. Same cycle: alloc x9 and we with rd_addr=9, wd=0xA. Expect busy[9]=1, x9=0xA, alloc_err=0.
5. Alloc x3 and x4, then pulse flush together with alloc x6. Expect x3/x4/x6 all not busy, alloc_err=0.
6. Same-cycle write x10=0x77 and read rs2=10. With REG_FILE_BYPASS_EN: rs2_data=0x77 that cycle. Without: old value, then 0x77 next cycle. Assert rst_n=0 mid-run: ready drops immediately and the INIT sweep repeats.
